// File: rtl/demux_rr_dispatcher_if.sv
// demux_rr_dispatcher_if: stream-in / four-channel demux-out bundle of the round-robin dispatcher
interface demux_rr_dispatcher_if #(
    parameter int DATA_W = 8
);
    logic [3:0]        en;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [3:0]        out_ready;
    logic [3:0]        out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        sel;
    logic              busy;
    modport master (
        output en, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, sel, busy
    );
    modport slave (
        input  en, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, sel, busy
    );
endinterface

// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: round-robin burst sequencing of one stream onto a 1:4 demux with a one-word hold stage
module demux_rr_dispatcher #(
    parameter int DATA_W = 8,
    parameter int BURST  = 4
) (
    input logic                 clk,
    input logic                 rst,
    demux_rr_dispatcher_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t            state;
    logic [1:0]        cur_ch;
    logic [1:0]        nxt_ch;
    logic [3:0]        cnt;
    logic              hold_valid;
    logic [1:0]        hold_ch;
    logic [DATA_W-1:0] hold_data;
    logic              accept;
    logic              deliver;
    logic              last;
    always_comb state = (bus.en != 4'b0) ? RUN : IDLE;
    // descending scan so the nearest enabled successor wins; falls back to cur_ch
    always_comb begin
        nxt_ch = cur_ch;
        for (int k = 3; k >= 1; k--)
            if (bus.en[cur_ch + 2'(k)]) nxt_ch = cur_ch + 2'(k);
    end
    always_comb begin
        deliver      = hold_valid && bus.out_ready[hold_ch];
        bus.in_ready = !rst && state == RUN && bus.en[cur_ch] && (!hold_valid || bus.out_ready[hold_ch]);
        accept       = bus.in_valid && bus.in_ready;
        last         = cnt == 4'(BURST - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_ch    <= 2'd0;
            hold_data  <= '0;
            cur_ch     <= 2'd0;
            cnt        <= 4'd0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_ch    <= cur_ch;
            hold_data  <= bus.in_data;
            cur_ch     <= last ? nxt_ch : cur_ch;
            cnt        <= last ? 4'd0 : cnt + 4'd1;
        end else begin
            if (deliver) hold_valid <= 1'b0;
            // a disabled current channel is skipped at the cost of one dead cycle
            if (state == RUN && !bus.en[cur_ch]) begin
                cur_ch <= nxt_ch;
                cnt    <= 4'd0;
            end
        end
    end
    always_comb begin
        bus.out_valid = hold_valid ? 4'(4'b0001 << hold_ch) : 4'b0000;
        bus.sel       = hold_ch;
        bus.out_data  = hold_data;
        bus.busy      = hold_valid;
    end
endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// tb_demux_rr_dispatcher: directed scenarios plus randomized traffic against a behavioural dispatcher model
module tb_demux_rr_dispatcher;
    localparam int BURST = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;
    demux_rr_dispatcher_if #(.DATA_W(8)) bus ();
    demux_rr_dispatcher #(.DATA_W(8), .BURST(BURST)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [1:0] m_ch = 2'd0;
    int         m_cnt = 0;
    logic       m_hv = 1'b0;
    logic [1:0] m_hch = 2'd0;
    logic [7:0] m_hd = 8'd0;
    logic [9:0] sb[$];

    function automatic logic [1:0] next_en(input logic [1:0] c);
        for (int k = 1; k <= 4; k++)
            if (bus.en[(int'(c) + k) % 4]) return 2'((int'(c) + k) % 4);
        return c;
    endfunction

    function automatic logic exp_ready();
        return !rst && bus.en != 4'b0 && bus.en[m_ch] && (!m_hv || bus.out_ready[m_hch]);
    endfunction

    function automatic logic [15:0] exp_vec();
        return {exp_ready(), m_hv ? 4'(4'b0001 << m_hch) : 4'b0000, m_hch, m_hd, m_hv};
    endfunction

    function automatic logic [15:0] obs_vec();
        return {bus.in_ready, bus.out_valid, bus.sel, bus.out_data, bus.busy};
    endfunction

    task automatic cycle();
        logic r;
        logic acc;
        logic dlv;
        r = exp_ready();
        acc = bus.in_valid && r;
        dlv = m_hv && bus.out_ready[m_hch];
        @(posedge clk);
        if (rst) begin
            m_ch = 2'd0; m_cnt = 0; m_hv = 1'b0; m_hch = 2'd0; m_hd = 8'd0;
            sb.delete();
        end else if (acc) begin
            sb.push_back({m_ch, bus.in_data});
            m_hv = 1'b1; m_hch = m_ch; m_hd = bus.in_data;
            m_cnt++;
            if (m_cnt == BURST) begin
                m_ch = next_en(m_ch);
                m_cnt = 0;
            end
        end else begin
            if (dlv) m_hv = 1'b0;
            if (bus.en != 4'b0 && !bus.en[m_ch]) begin
                m_ch = next_en(m_ch);
                m_cnt = 0;
            end
        end
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data = d;
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.en = 4'($urandom);
        bus.in_valid = 1'b1;
        bus.in_data = 8'($urandom);
        bus.out_ready = 4'($urandom);
        rst = 1'b1;
        cycle();
        cycle();
        total++; if (bus.out_valid !== 4'b0000) $display("FAIL reset_out_valid: got %b want 0000", bus.out_valid); else passed++;
        total++; if (bus.sel !== 2'b00) $display("FAIL reset_sel: got %b want 00", bus.sel); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passed++;
        rst = 1'b0;
        bus.en = 4'b1111;
        bus.in_valid = 1'b0;
        bus.out_ready = 4'b1111;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); else passed++;
    endtask

    task automatic test_rotation();
        logic [3:0] ev;
        bus.en = 4'b1111;
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(i);
            #1;
            total++; if (obs_vec() !== exp_vec()) $display("FAIL rot_model[%0d]: got %h want %h", i, obs_vec(), exp_vec()); else passed++;
            cycle();
            ev = 4'(4'b0001 << ((i / 4) % 4));
            total++; if (bus.out_valid !== ev || bus.out_data !== 8'(i)) $display("FAIL rot_word[%0d]: got %b/%h want %b/%h", i, bus.out_valid, bus.out_data, ev, 8'(i)); else passed++;
        end
        bus.in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_sparse();
        logic [3:0] ev;
        do_reset();
        bus.en = 4'b0101;
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(8'h40 + i);
            #1;
            total++; if (bus.in_ready !== 1'b1) $display("FAIL sparse_ready[%0d]: got %b want 1", i, bus.in_ready); else passed++;
            cycle();
            ev = 4'(4'b0001 << (((i / 4) % 2) * 2));
            total++; if (bus.out_valid !== ev) $display("FAIL sparse_ch[%0d]: got %b want %b", i, bus.out_valid, ev); else passed++;
        end
        bus.in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.en = 4'b1111;
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 6; i++) send(8'(i));
        bus.out_ready = 4'b1101;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h06;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.in_ready); else passed++;
            total++; if (bus.out_valid !== 4'b0010 || bus.out_data !== 8'h05) $display("FAIL bp_hold[%0d]: got %b/%h want 0010/05", i, bus.out_valid, bus.out_data); else passed++;
            cycle();
        end
        bus.out_ready = 4'b1111;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); else passed++;
        cycle();
        total++; if (bus.out_valid !== 4'b0010 || bus.out_data !== 8'h06) $display("FAIL bp_next_word: got %b/%h want 0010/06", bus.out_valid, bus.out_data); else passed++;
        bus.in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_disable();
        logic [3:0] ev;
        do_reset();
        bus.en = 4'b1111;
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 6; i++) send(8'(i));
        bus.en = 4'b1101;
        bus.out_ready = 4'b1101;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h06;
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL dis_dead_cycle: got %b want 0", bus.in_ready); else passed++;
        cycle();
        bus.out_ready = 4'b1111;
        #1;
        total++; if (bus.out_valid !== 4'b0010 || bus.out_data !== 8'h05) $display("FAIL dis_held_word: got %b/%h want 0010/05", bus.out_valid, bus.out_data); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL dis_resume_ready: got %b want 1", bus.in_ready); else passed++;
        for (int i = 6; i < 11; i++) begin
            bus.in_data = 8'(i);
            #1;
            total++; if (obs_vec() !== exp_vec()) $display("FAIL dis_model[%0d]: got %h want %h", i, obs_vec(), exp_vec()); else passed++;
            cycle();
            ev = (i < 10) ? 4'b0100 : 4'b1000;
            total++; if (bus.out_valid !== ev || bus.out_data !== 8'(i)) $display("FAIL dis_word[%0d]: got %b/%h want %b/%h", i, bus.out_valid, bus.out_data, ev, 8'(i)); else passed++;
        end
        bus.in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_idle();
        do_reset();
        bus.en = 4'b1111;
        bus.out_ready = 4'b0000;
        send(8'h33);
        bus.en = 4'b0000;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h34;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 4'b0001 || bus.out_data !== 8'h33) $display("FAIL idle_hold[%0d]: got %b/%b/%h want 0/0001/33", i, bus.in_ready, bus.out_valid, bus.out_data); else passed++;
            cycle();
        end
        bus.out_ready = 4'b1111;
        cycle();
        total++; if (bus.out_valid !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL idle_drain: got %b/%b want 0000/0", bus.out_valid, bus.busy); else passed++;
        bus.in_valid = 1'b0;
        bus.en = 4'b1111;
        bus.out_ready = 4'b0000;
        send(8'h44);
        total++; if (bus.out_valid !== 4'b0001 || bus.out_data !== 8'h44) $display("FAIL idle_cur_kept: got %b/%h want 0001/44", bus.out_valid, bus.out_data); else passed++;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        total++; if (bus.out_valid !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL reset_discard: got %b/%b want 0000/0", bus.out_valid, bus.busy); else passed++;
    endtask

    task automatic test_random();
        logic [9:0] ew;
        do_reset();
        bus.en = 4'b1111;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) bus.en = 4'($urandom_range(0, 15));
            bus.out_ready = (i > 395) ? 4'b1111 : 4'($urandom);
            bus.in_valid = (i < 395) && ($urandom_range(0, 3) != 0);
            bus.in_data = 8'($urandom);
            #1;
            total++; if (obs_vec() !== exp_vec()) $display("FAIL rand_model[%0d]: got %h want %h", i, obs_vec(), exp_vec()); else passed++;
            if ((bus.out_valid & bus.out_ready) != 4'b0) begin
                ew = (sb.size() != 0) ? sb.pop_front() : 10'h3ff;
                total++; if ({bus.sel, bus.out_data} !== ew) $display("FAIL rand_delivery[%0d]: got %h want %h", i, {bus.sel, bus.out_data}, ew); else passed++;
            end
            cycle();
        end
        total++; if (sb.size() != 0 || bus.busy !== 1'b0) $display("FAIL rand_drained: got %0d pending busy %b want 0/0", sb.size(), bus.busy); else passed++;
    endtask

    initial begin
        bus.en = 4'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'd0;
        bus.out_ready = 4'b0;
        #1;
        test_reset();
        test_rotation();
        test_sparse();
        test_backpressure();
        test_disable();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/demux_rr_dispatcher.md
# demux_rr_dispatcher

Round-robin dispatcher that sequences a single input word stream onto the four outputs of the 1:4 demultiplexer. It owns the demux select, advancing to the next enabled channel after a programmable burst or when the current channel is disabled. A one-entry registered output stage holds each word until the selected channel accepts it. It sits between the stream source and the four downstream consumers and drives the demux `S` and one-hot `Y` enable.

## Interface

Parameters:
- `DATA_W`, default 8: data word width.
- `BURST`, default 4: words sent to one channel before rotating. Legal range is 1..16.

Ports (clock and reset first):
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  4  channel enable mask; bit n enables channel n.
- `in_valid`  in  1  the source has a word.
- `in_data`  in  DATA_W  input word.
- `in_ready`  out  1  the dispatcher accepts `in_data` this cycle.
- `out_ready`  in  4  per-channel consumer ready.
- `out_valid`  out  4  one-hot valid (the demux `Y`); all zero when nothing is held.
- `out_data`  out  DATA_W  held word, shared by all channels.
- `sel`  out  2  channel of the held word (the demux `S`).
- `busy`  out  1  a word is held.

## Operation

Registers:
- `cur_ch` (2 bits): channel that receives the next accepted word.
- `cnt` (4 bits): words accepted for `cur_ch` in the current burst.
- Hold stage: `hold_valid`, `hold_ch`, `hold_data`.

States:
- IDLE: `en == 0`.
- RUN: `en != 0`.
- Transitions are evaluated every edge from the current `en`.

Signal definitions:
- `in_ready = RUN && en[cur_ch] && (!hold_valid || out_ready[hold_ch])`. It is combinational on `out_ready`, which allows back-to-back transfers.
- Accept: `in_valid && in_ready`. On accept:
  - `hold_data <= in_data`, `hold_ch <= cur_ch`, `hold_valid <= 1`.
  - `cnt` increments.
- Delivery: `hold_valid && out_ready[hold_ch]`. On delivery without a same-cycle accept, `hold_valid <= 0`. A simultaneous delivery and accept replaces the held word.

Outputs:
- `out_valid = hold_valid ? (4'b1 << hold_ch) : 4'b0`.
- `sel = hold_ch`, `out_data = hold_data`, `busy = hold_valid`.

Rotation:
- `next_en(c)` is the first enabled channel in the order c+1, c+2, c+3, c (mod 4).
- If an accept occurs with `cnt == BURST-1`: `cur_ch <= next_en(cur_ch)`, `cnt <= 0`.
- Else if `en[cur_ch] == 0` and `en != 0`: `cur_ch <= next_en(cur_ch)`, `cnt <= 0`. This takes one dead cycle with `in_ready = 0`.
- If only one channel is enabled, `next_en` returns that channel and `cnt` wraps to 0.

Boundary conditions:
- Clearing `en[hold_ch]` while a word is held never drops the word. It is delivered when `out_ready[hold_ch]` rises; `en` gates acceptance only.
- IDLE: `cur_ch` and `cnt` hold their values, `in_ready = 0`, and any held word still drains.
- No word is duplicated or lost under any `out_ready` pattern.

## Timing

- Reset (synchronous, takes effect at the edge where `rst` = 1): `hold_valid = 0`, `hold_ch = 0`, `hold_data = 0`, `cur_ch = 0`, `cnt = 0`. Resulting outputs: `out_valid = 0000`, `sel = 00`, `out_data = 0`, `busy = 0`, `in_ready = 0` while `rst` is high.
- Reset mid-operation discards any held word.
- Latency: a word accepted at edge k is presented on `out_valid`/`out_data` from cycle k+1.
- Throughput: 1 word/cycle while `out_ready[hold_ch]` is high and the current channel stays enabled.
- `sel`, `out_valid` and `out_data` are stable while `out_valid` is high and `out_ready[sel]` is low.
- A channel switch caused by burst completion costs no cycles. A switch caused by disabling the current channel costs one cycle.

## Test plan

- Reset: assert `rst` with arbitrary inputs, then check `out_valid = 0000`, `sel = 00`, `busy = 0`, `in_ready = 0`. Deassert with `en = 1111` and check `in_ready = 1`.
- Full rotation: `BURST = 4`, `en = 1111`, `out_ready = 1111`, `in_valid = 1`, data 0x00..0x13.
  - 0x00–0x03 go out on `out_valid = 0001`, `sel = 00`; 0x04–0x07 on `0010`; 0x08–0x0B on `0100`; 0x0C–0x0F on `1000`.
  - 0x10 returns to `0001`.
  - Each word appears one cycle after acceptance.
- Sparse mask: `en = 0101` gives the channel sequence 0,0,0,0,2,2,2,2,0… with no dead cycles.
- Backpressure: hold word 0x05 for channel 1 and drop `out_ready[1]` for 3 cycles.
  - `in_ready = 0`, with `out_valid = 0010` and `out_data = 0x05` stable throughout.
  - On release, the next word follows on the next cycle and none are lost.
- Disable mid-burst: after 2 words accepted for channel 1, clear `en[1]` while word 2 is held with `out_ready[1] = 0`.
  - Check one dead cycle, then the next word goes to channel 2 with `cnt` restarted.
  - The held word is still delivered on `out_valid = 0010` once `out_ready[1] = 1`.
- Idle and reset: with `en = 0000`, `in_ready` stays 0 and the held word drains. Assert `rst` while a word is held and check `out_valid = 0000` on the next cycle with no delivery.
